// File: rtl/data_l1_cache_pkg.sv
// data_l1_cache_pkg: shared widths and address-split geometry for the direct-mapped L1 data cache.
package data_l1_cache_pkg;
    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int NUM_LINES = 8;
    localparam int INDEX_W   = $clog2(NUM_LINES);
    localparam int TAG_W     = ADDR_W - INDEX_W;

    typedef logic [INDEX_W-1:0] index_t;
    typedef logic [TAG_W-1:0]   tag_t;
    typedef logic [DATA_W-1:0]  data_t;
endpackage

// File: rtl/data_l1_cache_if.sv
// data_l1_cache_if: load/store-unit side bus of the L1 data cache (one write port, one read port).
interface data_l1_cache_if;
    import data_l1_cache_pkg::*;
    logic [ADDR_W-1:0] WriteAddress_Full;
    logic [DATA_W-1:0] WriteValue;
    logic [ADDR_W-1:0] ReadAddress_Full;
    logic [DATA_W-1:0] ReadValue;
    logic              WriteHit;
    logic              ReadHit;
    logic              write;
    logic              read;

    modport master (
        output WriteAddress_Full, WriteValue, ReadAddress_Full, write, read,
        input  ReadValue, WriteHit, ReadHit
    );
    modport slave (
        input  WriteAddress_Full, WriteValue, ReadAddress_Full, write, read,
        output ReadValue, WriteHit, ReadHit
    );
endinterface

// File: rtl/data_l1_cache_l1_tag_data_array.sv
// l1_tag_data_array: valid/tag/data line storage with one synchronous write port
// and two combinational lookup ports (write-side hit check, read-side hit plus data).
module l1_tag_data_array
    import data_l1_cache_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   we,
    input  index_t w_idx,
    input  tag_t   w_tag,
    input  data_t  w_data,
    output logic   w_hit,
    input  index_t r_idx,
    input  tag_t   r_tag,
    output logic   r_hit,
    output data_t  r_data
);
    logic [NUM_LINES-1:0] valid_q, valid_d;
    tag_t                 tag_q  [NUM_LINES];
    tag_t                 tag_d  [NUM_LINES];
    data_t                data_q [NUM_LINES];
    data_t                data_d [NUM_LINES];

    // Lookups see pre-write contents, giving read-before-write on a shared line.
    assign w_hit  = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
    assign r_hit  = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    assign r_data = data_q[r_idx];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (we) begin
            valid_d[w_idx] = 1'b1;
            tag_d[w_idx]   = w_tag;
            data_d[w_idx]  = w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            valid_q <= '0;
        else
            valid_q <= valid_d;
        tag_q  <= tag_d;
        data_q <= data_d;
    end
endmodule

// File: rtl/data_l1_cache.sv
// data_l1_cache: direct-mapped, write-allocate L1 data cache with registered hit flags
// and read data; no backing-memory traffic.
module data_l1_cache
    import data_l1_cache_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    data_l1_cache_if.slave  bus
);
    index_t w_idx, r_idx;
    tag_t   w_tag, r_tag;
    logic   w_hit, r_hit;
    data_t  r_data;
    logic   write_hit_q, write_hit_d;
    logic   read_hit_q, read_hit_d;
    data_t  read_value_q, read_value_d;

    assign w_idx = bus.WriteAddress_Full[INDEX_W-1:0];
    assign w_tag = bus.WriteAddress_Full[ADDR_W-1:INDEX_W];
    assign r_idx = bus.ReadAddress_Full[INDEX_W-1:0];
    assign r_tag = bus.ReadAddress_Full[ADDR_W-1:INDEX_W];

    l1_tag_data_array u_array (
        .clk    (clk),
        .rst    (reset),
        .we     (bus.write),
        .w_idx  (w_idx),
        .w_tag  (w_tag),
        .w_data (bus.WriteValue),
        .w_hit  (w_hit),
        .r_idx  (r_idx),
        .r_tag  (r_tag),
        .r_hit  (r_hit),
        .r_data (r_data)
    );

    // Idle read port keeps the last read data; a read miss returns zero.
    always_comb begin
        write_hit_d  = bus.write && w_hit;
        read_hit_d   = bus.read && r_hit;
        read_value_d = bus.read ? (r_hit ? r_data : '0) : read_value_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_hit_q  <= 1'b0;
            read_hit_q   <= 1'b0;
            read_value_q <= '0;
        end else begin
            write_hit_q  <= write_hit_d;
            read_hit_q   <= read_hit_d;
            read_value_q <= read_value_d;
        end
    end

    assign bus.WriteHit  = write_hit_q;
    assign bus.ReadHit   = read_hit_q;
    assign bus.ReadValue = read_value_q;
endmodule

// File: tb/tb_data_l1_cache.sv
// tb_data_l1_cache: scoreboard bench; a cache model keyed by full address predicts each
// cycle's registered outputs, and a negedge monitor pops and compares them.
module tb_data_l1_cache;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_l1_cache_if bus();
    data_l1_cache dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic        wh;
        logic        rh;
        logic [15:0] rv;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int tests = 0;
    int fails = 0;

    // Model: each of 8 slots remembers the full address it holds and its value.
    logic        m_ok   [8];
    logic [15:0] m_addr [8];
    logic [15:0] m_val  [8];
    logic [15:0] m_last_rv;

    function automatic logic m_hit(input logic [15:0] a);
        return m_ok[a % 8] && (m_addr[a % 8] == a);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("WriteHit", {15'd0, bus.WriteHit}, {15'd0, e.wh});
            chk("ReadHit", {15'd0, bus.ReadHit}, {15'd0, e.rh});
            chk("ReadValue", bus.ReadValue, e.rv);
        end
    end

    task automatic cycle(input logic rst, input logic w, input logic [15:0] wa, input logic [15:0] wv,
                         input logic r, input logic [15:0] ra);
        exp_t x;
        reset                 = rst;
        bus.write             = w;
        bus.WriteAddress_Full = wa;
        bus.WriteValue        = wv;
        bus.read              = r;
        bus.ReadAddress_Full  = ra;
        if (rst) begin
            x = '{wh: 1'b0, rh: 1'b0, rv: 16'd0};
            for (int i = 0; i < 8; i++) m_ok[i] = 1'b0;
            m_last_rv = 16'd0;
        end else begin
            x.wh = w && m_hit(wa);
            x.rh = r && m_hit(ra);
            x.rv = r ? (m_hit(ra) ? m_val[ra % 8] : 16'd0) : m_last_rv;
            m_last_rv = x.rv;
            if (w) begin
                m_ok[wa % 8]   = 1'b1;
                m_addr[wa % 8] = wa;
                m_val[wa % 8]  = wv;
            end
        end
        @(posedge clk);
        q.push_back(x);
        #1;
    endtask

    function automatic logic [15:0] rand_addr();
        logic [12:0] tags [4] = '{13'h0000, 13'h0001, 13'h1000, 13'h1FFF};
        return {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7))};
    endfunction

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_ok[i] = 1'b0; m_addr[i] = 16'd0; m_val[i] = 16'd0;
        end
        m_last_rv = 16'd0;
        reset = 1'b1; bus.write = 1'b0; bus.read = 1'b0;
        bus.WriteAddress_Full = '0; bus.WriteValue = '0; bus.ReadAddress_Full = '0;
        @(posedge clk); #1;
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 1, 0, 23, 0, 0);
        cycle(0, 1, 0, 31, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 1, 1, 42, 1, 0);
        cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 1, 8, 62, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 8);
        cycle(0, 1, 2, 51, 1, 2);
        cycle(0, 0, 0, 0, 1, 2);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 1, 3, 77, 1, 2);
        cycle(0, 0, 0, 0, 1, 2);
        cycle(0, 0, 0, 0, 1, 8);
        cycle(0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 400; n++)
            cycle($urandom_range(0, 49) == 0, 1'($urandom), rand_addr(), 16'($urandom),
                  1'($urandom), rand_addr());
        cycle(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
